// File: rtl/sr_trace_buffer.sv
// sr_trace_buffer: instruction-trace capture unit for the schoolRISCV core.
// Records {pc, instr} on every valid CPU cycle into a circular RAM. Capture
// stops on a pc-match trigger plus a post-trigger window, or when a cycle
// watchdog expires. History is read back oldest-first through rd_idx.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   arm               pulse: clear history and start capture
//   valid, pc, instr  capture strobe and the executed instruction
//   trig_en, trig_pc  pc-match trigger enable and address
//   rd_idx            readout index (0 = oldest valid entry)
//   rd_pc, rd_instr   registered readout data (zero when rd_idx >= fill)
//   fill              valid entries, saturating at DEPTH
//   state             0 IDLE, 1 RUN, 2 POST, 3 DONE
//   triggered         sticky trigger flag since arm
//   timeout           sticky watchdog flag since arm
//   cycle             valid cycles since arm, saturating
module sr_trace_buffer #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned POST_TRIG = 4,
  parameter int unsigned TIMEOUT   = 600,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               valid,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [ADDR_W-1:0]  rd_idx,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [ADDR_W:0]    fill,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned WordW  = PC_W + INSTR_W;
  localparam logic [ADDR_W:0]   DepthVal   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PostVal    = ADDR_W'(POST_TRIG);
  localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT);
  localparam bit                WdogEn     = (TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPost = 2'd2, StDone = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                triggered_q, triggered_d;
  logic                timeout_q, timeout_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [PC_W-1:0]     rd_pc_q, rd_pc_d;
  logic [INSTR_W-1:0]  rd_instr_q, rd_instr_d;

  logic [WordW-1:0]    mem_q [Depth];
  logic                mem_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   oldest;
  logic [WordW-1:0]    rd_word;
  logic                rd_hit;
  logic                capture;
  logic                trig_hit;

  // Next-state logic for control and capture bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    cycle_d     = cycle_q;
    triggered_d = triggered_q;
    timeout_d   = timeout_q;
    post_cnt_d  = post_cnt_q;
    mem_we      = 1'b0;
    capture     = valid && (state_q == StRun || state_q == StPost);
    trig_hit    = (state_q == StRun) && trig_en && (pc == trig_pc);

    if (arm) begin
      // arm wins over everything else in the same cycle, including capture.
      state_d     = StRun;
      wr_ptr_d    = '0;
      fill_d      = '0;
      cycle_d     = '0;
      triggered_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (capture) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != DepthVal) fill_d = fill_q + 1'b1;
      if (cycle_q != '1) cycle_d = cycle_q + 1'b1;

      if (state_q == StRun) begin
        if (trig_hit) begin
          triggered_d = 1'b1;
          post_cnt_d  = PostVal;
          state_d     = (POST_TRIG == 0) ? StDone : StPost;
        end
      end else begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == ADDR_W'(1)) state_d = StDone;
      end

      // Watchdog fires on the capture that brings cycle up to TIMEOUT.
      if (WdogEn && cycle_d == TimeoutVal) begin
        timeout_d = 1'b1;
        state_d   = StDone;
      end
    end
  end

  // Readout address: oldest entry is slot 0 until the buffer has wrapped.
  always_comb begin
    oldest     = (fill_q < DepthVal) ? '0 : wr_ptr_q;
    rd_addr    = oldest + rd_idx;
    rd_word    = mem_q[rd_addr];
    rd_hit     = {1'b0, rd_idx} < fill_q;
    rd_pc_d    = rd_hit ? rd_word[WordW-1:INSTR_W] : '0;
    rd_instr_d = rd_hit ? rd_word[INSTR_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      cycle_q     <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
      post_cnt_q  <= '0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      cycle_q     <= cycle_d;
      triggered_q <= triggered_d;
      timeout_q   <= timeout_d;
      post_cnt_q  <= post_cnt_d;
      rd_pc_q     <= rd_pc_d;
      rd_instr_q  <= rd_instr_d;
    end
  end

  // Trace RAM has no reset; the read above sees pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {pc, instr};
  end

  assign rd_pc     = rd_pc_q;
  assign rd_instr  = rd_instr_q;
  assign fill      = fill_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign timeout   = timeout_q;
  assign cycle     = cycle_q;

endmodule

// File: doc/sr_trace_buffer.md
Name: sr_trace_buffer

Overview:
- Synthesisable, parametrised instruction-trace capture unit for the schoolRISCV core; replaces print-only simulation tracing with an on-chip circular history.
- Each valid CPU cycle it records {pc, instr} into a circular RAM.
- Supports a pc-match trigger with a post-trigger window and a cycle-timeout watchdog.
- History is read back through an indexed debug port, oldest entry first; sits beside sm_cpu in sm_top.

Parameters:
- ADDR_W, 4, log2 of buffer depth (DEPTH = 2**ADDR_W entries)
- PC_W, 32, captured pc width
- INSTR_W, 32, captured instruction width
- POST_TRIG, 4, entries captured after the trigger entry before freezing (0..DEPTH-1)
- TIMEOUT, 600, valid cycles after arm before forced freeze (0 = watchdog disabled)
- CNT_W, 16, cycle counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  single-cycle pulse: clear the buffer and start capture
- valid  in  1  CPU executed an instruction this cycle (capture strobe)
- pc  in  PC_W  pc of the executed instruction
- instr  in  INSTR_W  executed instruction word
- trig_en  in  1  enable pc-match trigger
- trig_pc  in  PC_W  trigger address
- rd_idx  in  ADDR_W  readout index, 0 = oldest valid entry
- rd_pc  out  PC_W  pc at rd_idx (registered)
- rd_instr  out  INSTR_W  instr at rd_idx (registered)
- fill  out  ADDR_W+1  number of valid entries, saturating at DEPTH
- state  out  2  0 IDLE, 1 RUN, 2 POST, 3 DONE
- triggered  out  1  sticky: trigger fired since arm
- timeout  out  1  sticky: watchdog expired since arm
- cycle  out  CNT_W  valid cycles since arm, saturating at all-ones

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_ptr=0, fill=0, cycle=0, triggered=0, timeout=0, rd_pc=0, rd_instr=0, post counter=0. RAM contents are don't-care.
- arm=1 (any state) on a clock edge: wr_ptr=0, fill=0, cycle=0, triggered=0, timeout=0, state<=RUN. No capture occurs in the arm cycle.
- arm overrides valid, trigger and timeout in the same cycle.
- Capture happens in RUN or POST when valid=1:
  - RAM[wr_ptr] <= {pc, instr}; wr_ptr wraps DEPTH-1 -> 0.
  - fill increments up to DEPTH and then holds.
  - cycle increments, saturating.
- RUN -> POST: valid && trig_en && pc==trig_pc.
  - The matching entry is captured; triggered<=1; post counter<=POST_TRIG.
  - If POST_TRIG=0, go directly to DONE instead.
- POST: each captured entry decrements the post counter. The capture that takes it from 1 to 0 moves the state to DONE. Further pc matches are ignored.
- Watchdog (TIMEOUT != 0), active in RUN or POST: when a valid cycle makes cycle==TIMEOUT, that entry is captured, timeout<=1 and state<=DONE. If this coincides with a trigger, both flags are set and the state goes to DONE.
- DONE and IDLE: no capture; cycle and fill hold; only arm leaves these states.
- Readout (1-cycle latency; rd_idx sampled at edge N, data valid after edge N):
  - Oldest entry = (fill<DEPTH) ? 0 : wr_ptr.
  - Physical address = (oldest + rd_idx) mod DEPTH.
  - If rd_idx >= fill, rd_pc=0 and rd_instr=0.
  - Readout is legal in any state. A read and write to the same address in the same cycle returns the old data.
- Widths: all pointer arithmetic is modulo DEPTH; fill is ADDR_W+1 bits so the value DEPTH is representable.

Test Plan:
- Reset mid-RUN after 5 captures -> all outputs return to their reset values immediately, with no clock edge required. After release, state=IDLE and valid is ignored.
- arm, then 3 valid cycles with pc=0,4,8 -> fill=3, cycle=3, rd_idx=0/1/2 return pc 0/4/8 one cycle later, rd_idx=3 returns 0.
- DEPTH=16, 20 valid cycles pc=0..76 step 4 -> fill=16, rd_idx=0 gives pc=16, rd_idx=15 gives pc=76 (wrap verified).
- trig_en=1, trig_pc=0x20, POST_TRIG=4, pc stream 0,4,8,... -> state POST at pc 0x20, DONE after pc 0x30, triggered=1, newest entry is pc 0x30, later valids are not captured.
- TIMEOUT=10, no trigger -> DONE after the 10th valid cycle, timeout=1, cycle=10. A fresh arm clears timeout and restarts capture.
- arm asserted in the same cycle as a pc match -> no capture, triggered=0, state=RUN, fill=0.
